// File: rtl/shared_chi5_inv_sifa.sv
// Two-share masked inverse Chi5 row with optional duplicated datapath for SIFA/fault detection.
// Optional feature macro: CHI5INV_DUP_EN (defined: second instance + share comparator).

module shared_chi5_inv_sifa_dp (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       mul1,
    input  logic       sum1,
    input  logic       mul2,
    input  logic [4:0] y_sh0,
    input  logic [4:0] y_sh1,
    input  logic [9:0] rnd,
    output logic [4:0] x_sh0_c,
    output logic [4:0] x_sh1_c
);
    localparam int unsigned W = 5;
    localparam int unsigned RW = 10;

    logic [W-1:0]  ys0, ys1;
    logic [RW-1:0] rs;
    logic [W-1:0]  cr0, cr1;
    logic [W-1:0]  z_sh0, z_sh1;
    logic [W-1:0]  p0, p1, q0_l1, q1_l1, q0_l2, q1_l2;

    // bit i of the result is v[i+1] / v[i+2], indices mod 5
    function automatic logic [W-1:0] rot1(input logic [W-1:0] v);
        return {v[0], v[4:1]};
    endfunction

    function automatic logic [W-1:0] rot2(input logic [W-1:0] v);
        return {v[1:0], v[4:2]};
    endfunction

    // First AND operand is ~y_{i+1}; the inversion lives in share 0 only
    always_comb begin
        p0    = ~rot1(ys0);
        p1    = rot1(ys1);
        q0_l1 = rot2(ys0);
        q1_l1 = rot2(ys1);
        q0_l2 = rot2(z_sh0);
        q1_l2 = rot2(z_sh1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ys0   <= '0;
            ys1   <= '0;
            rs    <= '0;
            cr0   <= '0;
            cr1   <= '0;
            z_sh0 <= '0;
            z_sh1 <= '0;
        end else begin
            if (load) begin
                ys0 <= y_sh0;
                ys1 <= y_sh1;
                rs  <= rnd;
            end
            if (mul1) begin
                cr0 <= (p0 & q1_l1) ^ rs[4:0];
                cr1 <= (p1 & q0_l1) ^ rs[4:0];
            end
            if (sum1) begin
                z_sh0 <= ys0 ^ (p0 & q0_l1) ^ cr0;
                z_sh1 <= ys1 ^ (p1 & q1_l1) ^ cr1;
            end
            if (mul2) begin
                cr0 <= (p0 & q1_l2) ^ rs[9:5];
                cr1 <= (p1 & q0_l2) ^ rs[9:5];
            end
        end
    end

    // Layer-2 domain terms join the registered cross terms
    always_comb begin
        x_sh0_c = ys0 ^ (p0 & q0_l2) ^ cr0;
        x_sh1_c = ys1 ^ (p1 & q1_l2) ^ cr1;
    end
endmodule

module shared_chi5_inv_sifa #(
    parameter int unsigned STICKY_FAULT  = 1,
    parameter int unsigned ZERO_ON_FAULT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] port_a_in,
    input  logic [1:0] port_b_in,
    input  logic [1:0] port_c_in,
    input  logic [1:0] port_d_in,
    input  logic [1:0] port_e_in,
    input  logic [9:0] port_rand,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] port_a_out,
    output logic [1:0] port_b_out,
    output logic [1:0] port_c_out,
    output logic [1:0] port_d_out,
    output logic [1:0] port_e_out,
    output logic [1:0] port_det_out,
    output logic       fault_sticky
);
    localparam int unsigned W = 5;
    localparam int unsigned DW = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1_MUL = 3'd1,
        L1_SUM = 3'd2,
        L2_MUL = 3'd3,
        L2_SUM = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic          load_c, mul1_c, sum1_c, mul2_c, sum2_c;
    logic          in_ready_q, out_valid_q, fault_q;
    logic [W-1:0]  y_sh0, y_sh1;
    logic [W-1:0]  x0_sh0_c, x0_sh1_c;
    logic [W-1:0]  x_sh0_q, x_sh1_q;
    logic [DW-1:0] det_c, det_q;
    logic          mismatch_c, zap_c;

    assign y_sh0 = {port_e_in[0], port_d_in[0], port_c_in[0], port_b_in[0], port_a_in[0]};
    assign y_sh1 = {port_e_in[1], port_d_in[1], port_c_in[1], port_b_in[1], port_a_in[1]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && in_ready_q) state_nxt = L1_MUL;
            L1_MUL:  state_nxt = L1_SUM;
            L1_SUM:  state_nxt = L2_MUL;
            L2_MUL:  state_nxt = L2_SUM;
            L2_SUM:  state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath strobes; accept also waits for in_ready so the post-reset cycle is refused
    always_comb begin
        load_c = 1'b0;
        mul1_c = 1'b0;
        sum1_c = 1'b0;
        mul2_c = 1'b0;
        sum2_c = 1'b0;
        case (state)
            IDLE:    load_c = in_valid && in_ready_q;
            L1_MUL:  mul1_c = 1'b1;
            L1_SUM:  sum1_c = 1'b1;
            L2_MUL:  mul2_c = 1'b1;
            L2_SUM:  sum2_c = 1'b1;
            default: ;
        endcase
    end

    shared_chi5_inv_sifa_dp u_dp0 (
        .clk     (clk),
        .reset   (reset),
        .load    (load_c),
        .mul1    (mul1_c),
        .sum1    (sum1_c),
        .mul2    (mul2_c),
        .y_sh0   (y_sh0),
        .y_sh1   (y_sh1),
        .rnd     (port_rand),
        .x_sh0_c (x0_sh0_c),
        .x_sh1_c (x0_sh1_c)
    );

`ifdef CHI5INV_DUP_EN
    logic [W-1:0] y_sh0_buf, y_sh1_buf;
    logic [9:0]   rand_buf;
    logic [W-1:0] x1_sh0_c, x1_sh1_c;

    // Separate copies so a single fault on the input nets reaches only one instance
    assign y_sh0_buf = y_sh0;
    assign y_sh1_buf = y_sh1;
    assign rand_buf  = port_rand;

    shared_chi5_inv_sifa_dp u_dp1 (
        .clk     (clk),
        .reset   (reset),
        .load    (load_c),
        .mul1    (mul1_c),
        .sum1    (sum1_c),
        .mul2    (mul2_c),
        .y_sh0   (y_sh0_buf),
        .y_sh1   (y_sh1_buf),
        .rnd     (rand_buf),
        .x_sh0_c (x1_sh0_c),
        .x_sh1_c (x1_sh1_c)
    );

    always_comb begin
        det_c[0] = (x0_sh0_c == x1_sh0_c);
        det_c[1] = (x0_sh1_c == x1_sh1_c);
    end
`else
    assign det_c = 2'b11;
`endif

    assign mismatch_c = (det_c != 2'b11);
    assign zap_c      = (ZERO_ON_FAULT != 0) && mismatch_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            x_sh0_q     <= '0;
            x_sh1_q     <= '0;
            det_q       <= 2'b11;
            fault_q     <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == HOLD);
            if (sum2_c) begin
                x_sh0_q <= zap_c ? '0 : x0_sh0_c;
                x_sh1_q <= zap_c ? '0 : x0_sh1_c;
                det_q   <= det_c;
                fault_q <= (STICKY_FAULT != 0) ? (fault_q | mismatch_c) : mismatch_c;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign port_det_out = det_q;
    assign fault_sticky = fault_q;
    assign port_a_out   = {x_sh1_q[0], x_sh0_q[0]};
    assign port_b_out   = {x_sh1_q[1], x_sh0_q[1]};
    assign port_c_out   = {x_sh1_q[2], x_sh0_q[2]};
    assign port_d_out   = {x_sh1_q[3], x_sh0_q[3]};
    assign port_e_out   = {x_sh1_q[4], x_sh0_q[4]};
endmodule

// File: tb/tb_shared_chi5_inv_sifa.sv
// Directed bench for shared_chi5_inv_sifa: reset, known vectors, all 32 rows, stall, fault and abort.
module tb_shared_chi5_inv_sifa;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, out_valid, out_ready, fault_sticky;
    logic [1:0] port_a_in, port_b_in, port_c_in, port_d_in, port_e_in;
    logic [1:0] port_a_out, port_b_out, port_c_out, port_d_out, port_e_out;
    logic [1:0] port_det_out;
    logic [9:0] port_rand;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_chi5_inv_sifa dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .port_a_in(port_a_in), .port_b_in(port_b_in), .port_c_in(port_c_in),
        .port_d_in(port_d_in), .port_e_in(port_e_in), .port_rand(port_rand),
        .out_valid(out_valid), .out_ready(out_ready),
        .port_a_out(port_a_out), .port_b_out(port_b_out), .port_c_out(port_c_out),
        .port_d_out(port_d_out), .port_e_out(port_e_out),
        .port_det_out(port_det_out), .fault_sticky(fault_sticky)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] chi5(input logic [4:0] x);
        logic [4:0] y;
        for (int i = 0; i < 5; i++)
            y[i] = x[i] ^ (~x[(i + 1) % 5] & x[(i + 2) % 5]);
        return y;
    endfunction

    function automatic logic [4:0] inv5(input logic [4:0] y);
        for (int k = 0; k < 32; k++)
            if (chi5(5'(k)) == y) return 5'(k);
        return 5'h0;
    endfunction

    function automatic logic [4:0] out_sh(input bit s);
        return {port_e_out[s], port_d_out[s], port_c_out[s], port_b_out[s], port_a_out[s]};
    endfunction

    task automatic put_row(input logic [4:0] y0, input logic [4:0] y1, input logic [9:0] rnd);
        port_a_in = {y1[0], y0[0]};
        port_b_in = {y1[1], y0[1]};
        port_c_in = {y1[2], y0[2]};
        port_d_in = {y1[3], y0[3]};
        port_e_in = {y1[4], y0[4]};
        port_rand = rnd;
        in_valid  = 1'b1;
    endtask

    // Returns on the falling edge right after the accepting clock edge; inputs then scrambled
    task automatic start_row(input logic [4:0] y0, input logic [4:0] y1, input logic [9:0] rnd);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
        put_row(y0, y1, rnd);
        @(negedge clk);
        in_valid  = 1'b0;
        port_rand = 10'($urandom);
        port_a_in = 2'($urandom);
        port_c_in = 2'($urandom);
    endtask

    task automatic wait_valid(input string tag);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_row(input string tag, input logic [4:0] y0, input logic [4:0] y1,
                           input logic [9:0] rnd, output logic [4:0] xs0, output logic [4:0] xs1);
        start_row(y0, y1, rnd);
        wait_valid(tag);
        xs0 = out_sh(1'b0);
        xs1 = out_sh(1'b1);
        check_eq({tag, "_x"}, 32'(xs0 ^ xs1), 32'(inv5(y0 ^ y1)));
        check_eq({tag, "_det"}, 32'(port_det_out), 32'h3);
        retire();
    endtask

    initial begin
        logic [4:0] s0, s1, s0b, s1b, y, m, yb, zf;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        put_row(5'h0, 5'h0, 10'h0);
        in_valid = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sh0", 32'(out_sh(1'b0)), 32'h0);
        check_eq("rst_sh1", 32'(out_sh(1'b1)), 32'h0);
        check_eq("rst_det", 32'(port_det_out), 32'h3);
        check_eq("rst_fault", 32'(fault_sticky), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready_after", 32'(in_ready), 32'd1);

        // y=(1,1,0,1,0) unmasked, zero randomness -> x=(1,1,0,0,0), share 1 stays zero
        run_row("v1", 5'b01011, 5'h00, 10'h000, s0, s1);
        check_eq("v1_sh0", 32'(s0), 32'h03);
        check_eq("v1_sh1", 32'(s1), 32'h00);
        check_eq("v1_fault", 32'(fault_sticky), 32'd0);

        // y=(1,0,0,1,0) with share1 all ones; complementary randomness flips every output share bit
        run_row("v2a", 5'b10110, 5'h1F, 10'h3A5, s0, s1);
        check_eq("v2a_xval", 32'(s0 ^ s1), 32'h01);
        run_row("v2b", 5'b10110, 5'h1F, 10'h05A, s0b, s1b);
        check_eq("v2_sh0_delta", 32'(s0 ^ s0b), 32'h1F);
        check_eq("v2_sh1_delta", 32'(s1 ^ s1b), 32'h1F);

        // All 32 rows with random masks; row 7 holds out_ready high before out_valid
        for (int k = 0; k < 32; k++) begin
            y = 5'(k);
            m = 5'($urandom);
            if (k == 7) out_ready = 1'b1;
            run_row("exh", y ^ m, m, 10'($urandom), s0, s1);
            check_eq("exh_chi", 32'(chi5(s0 ^ s1)), 32'(y));
        end

        // HOLD stall with a competing row pending
        y = 5'h16; m = 5'h09; yb = 5'h0E;
        start_row(y ^ m, m, 10'h1B3);
        wait_valid("stall");
        put_row(yb ^ 5'h15, 5'h15, 10'h2E1);
        for (int k = 0; k < 10; k++) begin
            check_eq("stall_x", 32'(out_sh(1'b0) ^ out_sh(1'b1)), 32'(inv5(y)));
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("stall_idle_ready", 32'(in_ready), 32'd1);
        check_eq("stall_idle_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("stall_accepted", 32'(in_ready), 32'd0);
        wait_valid("stall_b");
        check_eq("stall_b_x", 32'(out_sh(1'b0) ^ out_sh(1'b1)), 32'(inv5(yb)));
        retire();

`ifdef CHI5INV_DUP_EN
        // Flip instance-0 share-1 z_2 after the layer-2 cross terms are registered
        start_row(5'h0D, 5'h13, 10'h2C7);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        zf = dut.u_dp0.z_sh1 ^ 5'b00100;
        force dut.u_dp0.z_sh1 = zf;
        @(negedge clk);
        release dut.u_dp0.z_sh1;
        check_eq("flt_valid", 32'(out_valid), 32'd1);
        check_eq("flt_det", 32'(port_det_out), 32'h1);
        check_eq("flt_sh0", 32'(out_sh(1'b0)), 32'h0);
        check_eq("flt_sh1", 32'(out_sh(1'b1)), 32'h0);
        check_eq("flt_sticky", 32'(fault_sticky), 32'd1);
        retire();
        run_row("post_flt", 5'h1A, 5'h07, 10'h155, s0, s1);
        check_eq("post_flt_sticky", 32'(fault_sticky), 32'd1);
`else
        run_row("single", 5'h1A, 5'h07, 10'h155, s0, s1);
        check_eq("single_fault", 32'(fault_sticky), 32'd0);
`endif

        // Nonzero outputs first, then reset during L2_MUL aborts the next row
        run_row("pre_abort", 5'h15, 5'h03, 10'h0F0, s0, s1);
        check_eq("pre_abort_nz", 32'((s0 | s1) != 5'h0), 32'd1);
        start_row(5'h1C, 5'h05, 10'h333);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_valid", 32'(out_valid), 32'd0);
        check_eq("abort_sh0", 32'(out_sh(1'b0)), 32'h0);
        check_eq("abort_sh1", 32'(out_sh(1'b1)), 32'h0);
        check_eq("abort_det", 32'(port_det_out), 32'h3);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        check_eq("abort_fault", 32'(fault_sticky), 32'd0);
        @(negedge clk);
        check_eq("abort_in_ready_next", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check_eq("abort_no_output", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
